// File: rtl/cache_l1d_assoc_pkg.sv
// ============================================================================
// Module      : cache_l1d_assoc_pkg
// Description : Shared types, FSM encoding and geometry helpers for the L1D.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_l1d_assoc_pkg;
    localparam int PTR_W   = 16;
    localparam int WORD_W  = 32;
    localparam int QPTR_W  = PTR_W - 2;
    localparam int QWORD_W = 4 * WORD_W;

    typedef logic [PTR_W-1:0]   ptr;
    typedef logic [WORD_W-1:0]  word;
    typedef logic [QPTR_W-1:0]  qptr;
    typedef logic [QWORD_W-1:0] qword;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOOKUP     = 3'd1,
        ST_WB         = 3'd2,
        ST_REFILL     = 3'd3,
        ST_FLUSH_SCAN = 3'd4,
        ST_FLUSH_WB   = 3'd5
    } l1d_state_t;

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int sets);
        return QPTR_W - $clog2(sets);
    endfunction

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction
endpackage

`default_nettype wire

// File: rtl/cache_l1d_assoc_lru.sv
// ============================================================================
// Module      : cache_lru
// Description : Per-set age ordering; age 0 = MRU, age WAYS-1 = victim.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_lru
    import cache_l1d_assoc_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [idx_w(SETS)-1:0]    i_set,
    input  logic [way_w(WAYS)-1:0]    i_touch_way,
    input  logic                      i_touch_en,
    output logic [way_w(WAYS)-1:0]    o_victim
);
    localparam int WW = way_w(WAYS);

    logic [WW-1:0] r_age [SETS][WAYS];

    // Ages always form a permutation, so reset seeds them with the way index.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    r_age[s][w] <= WW'(w);
        end else if (i_touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WW'(w) == i_touch_way)
                    r_age[i_set][w] <= '0;
                else if (r_age[i_set][w] < r_age[i_set][i_touch_way])
                    r_age[i_set][w] <= r_age[i_set][w] + WW'(1);
            end
        end
    end

    always_comb begin
        o_victim = '0;
        for (int w = 0; w < WAYS; w++)
            if (r_age[i_set][w] == WW'(WAYS - 1))
                o_victim = WW'(w);
    end
endmodule

`default_nettype wire

// File: rtl/cache_l1d_assoc.sv
// ============================================================================
// Module      : cache_l1d_assoc
// Description : Write-back, write-allocate N-way L1 data cache with flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_l1d_assoc
    import cache_l1d_assoc_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int SETS  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ldst_start,
    input  logic             ldst_write,
    input  ptr               ldst_addr,
    input  logic [3:0]       ldst_byte_en,
    input  word              ldst_data_wr,
    output logic             ldst_ready,
    output word              ldst_data_rd,
    input  logic             flush_req,
    output logic             flush_done,
    output logic             data_start,
    output logic             data_write,
    output qptr              data_addr,
    output qword             data_data_wr,
    input  qword             data_data_rd,
    input  logic             data_ready,
    output logic [CNT_W-1:0] cnt_hit,
    output logic [CNT_W-1:0] cnt_miss
);
    localparam int IW = idx_w(SETS);
    localparam int TW = tag_w(SETS);
    localparam int WW = way_w(WAYS);

    l1d_state_t       r_state;
    ptr               r_req_addr;
    logic             r_req_write;
    logic [3:0]       r_req_be;
    word              r_req_wdata;
    logic [WW-1:0]    r_victim;
    logic             r_refilled;
    logic [IW-1:0]    r_fl_set;
    logic [WW-1:0]    r_fl_way;
    logic             r_flush_arm;
    logic             r_data_start, r_data_write, r_flush_done;
    qptr              r_data_addr;
    qword             r_data_wdata;
    logic [CNT_W-1:0] r_cnt_hit, r_cnt_miss;

    logic             r_valid [WAYS][SETS];
    logic             r_dirty [WAYS][SETS];
    logic [TW-1:0]    r_tag   [WAYS][SETS];
    qword             r_data  [WAYS][SETS];

    logic [1:0]       w_off;
    logic [IW-1:0]    w_idx;
    logic [TW-1:0]    w_tag;
    logic             w_hit, w_inv_found, w_ready, w_accept, w_fl_last;
    logic [WW-1:0]    w_hit_way, w_inv_way, w_lru_victim, w_victim;
    qword             w_hit_line;
    word              w_hit_word, w_merged;

    assign w_off = r_req_addr[1:0];
    assign w_idx = r_req_addr[IW+1:2];
    assign w_tag = r_req_addr[PTR_W-1:IW+2];

    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = 0; w < WAYS; w++)
            if (r_valid[w][w_idx] && r_tag[w][w_idx] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WW'(w);
            end
        // Descending scan leaves the lowest-numbered invalid way selected.
        for (int w = WAYS - 1; w >= 0; w--)
            if (!r_valid[w][w_idx]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WW'(w);
            end
    end

    assign w_victim   = w_inv_found ? w_inv_way : w_lru_victim;
    assign w_hit_line = r_data[w_hit_way][w_idx];
    assign w_hit_word = w_hit_line[{w_off, 5'b0} +: WORD_W];
    assign w_ready    = (r_state == ST_LOOKUP) && w_hit && !rst;
    assign w_accept   = ldst_start && ((r_state == ST_IDLE) || w_ready);
    assign w_fl_last  = (r_fl_set == IW'(SETS - 1)) && (r_fl_way == WW'(WAYS - 1));

    always_comb begin
        w_merged = w_hit_word;
        for (int b = 0; b < 4; b++)
            if (r_req_be[b])
                w_merged[8*b +: 8] = r_req_wdata[8*b +: 8];
    end

    cache_lru #(.WAYS(WAYS), .SETS(SETS)) u_lru (
        .clk         (clk),
        .rst         (rst),
        .i_set       (w_idx),
        .i_touch_way (w_hit_way),
        .i_touch_en  (w_ready),
        .o_victim    (w_lru_victim)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_req_addr   <= '0;
            r_req_write  <= 1'b0;
            r_req_be     <= '0;
            r_req_wdata  <= '0;
            r_victim     <= '0;
            r_refilled   <= 1'b0;
            r_fl_set     <= '0;
            r_fl_way     <= '0;
            r_flush_arm  <= 1'b1;
            r_data_start <= 1'b0;
            r_data_write <= 1'b0;
            r_data_addr  <= '0;
            r_data_wdata <= '0;
            r_flush_done <= 1'b0;
            r_cnt_hit    <= '0;
            r_cnt_miss   <= '0;
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++) begin
                    r_valid[w][s] <= 1'b0;
                    r_dirty[w][s] <= 1'b0;
                end
        end else begin
            r_data_start <= 1'b0;
            r_flush_done <= 1'b0;
            if (!flush_req)
                r_flush_arm <= 1'b1;
            if (w_accept) begin
                r_req_addr  <= ldst_addr;
                r_req_write <= ldst_write;
                r_req_be    <= ldst_byte_en;
                r_req_wdata <= ldst_data_wr;
                r_refilled  <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept)
                        r_state <= ST_LOOKUP;
                    else if (flush_req && r_flush_arm) begin
                        r_state     <= ST_FLUSH_SCAN;
                        r_flush_arm <= 1'b0;
                        r_fl_set    <= '0;
                        r_fl_way    <= '0;
                    end
                end
                ST_LOOKUP: begin
                    if (w_hit) begin
                        // The lookup that completes a refill was already counted as a miss.
                        if (!r_refilled && r_cnt_hit != '1)
                            r_cnt_hit <= r_cnt_hit + CNT_W'(1);
                        if (r_req_write)
                            r_dirty[w_hit_way][w_idx] <= 1'b1;
                        r_state <= w_accept ? ST_LOOKUP : ST_IDLE;
                    end else begin
                        if (r_cnt_miss != '1)
                            r_cnt_miss <= r_cnt_miss + CNT_W'(1);
                        r_victim     <= w_victim;
                        r_data_start <= 1'b1;
                        if (r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx]) begin
                            r_state      <= ST_WB;
                            r_data_write <= 1'b1;
                            r_data_addr  <= {r_tag[w_victim][w_idx], w_idx};
                            r_data_wdata <= r_data[w_victim][w_idx];
                        end else begin
                            r_state      <= ST_REFILL;
                            r_data_write <= 1'b0;
                            r_data_addr  <= {w_tag, w_idx};
                        end
                    end
                end
                ST_WB: begin
                    if (data_ready) begin
                        r_state      <= ST_REFILL;
                        r_data_start <= 1'b1;
                        r_data_write <= 1'b0;
                        r_data_addr  <= {w_tag, w_idx};
                    end
                end
                ST_REFILL: begin
                    if (data_ready) begin
                        r_valid[r_victim][w_idx] <= 1'b1;
                        r_dirty[r_victim][w_idx] <= 1'b0;
                        r_refilled               <= 1'b1;
                        r_state                  <= ST_LOOKUP;
                    end
                end
                ST_FLUSH_SCAN: begin
                    r_valid[r_fl_way][r_fl_set] <= 1'b0;
                    r_dirty[r_fl_way][r_fl_set] <= 1'b0;
                    if (r_valid[r_fl_way][r_fl_set] && r_dirty[r_fl_way][r_fl_set]) begin
                        r_state      <= ST_FLUSH_WB;
                        r_data_start <= 1'b1;
                        r_data_write <= 1'b1;
                        r_data_addr  <= {r_tag[r_fl_way][r_fl_set], r_fl_set};
                        r_data_wdata <= r_data[r_fl_way][r_fl_set];
                    end else if (w_fl_last) begin
                        r_state      <= ST_IDLE;
                        r_flush_done <= 1'b1;
                    end else if (r_fl_way == WW'(WAYS - 1)) begin
                        r_fl_way <= '0;
                        r_fl_set <= r_fl_set + IW'(1);
                    end else
                        r_fl_way <= r_fl_way + WW'(1);
                end
                ST_FLUSH_WB: begin
                    if (data_ready) begin
                        if (w_fl_last) begin
                            r_state      <= ST_IDLE;
                            r_flush_done <= 1'b1;
                        end else begin
                            r_state <= ST_FLUSH_SCAN;
                            if (r_fl_way == WW'(WAYS - 1)) begin
                                r_fl_way <= '0;
                                r_fl_set <= r_fl_set + IW'(1);
                            end else
                                r_fl_way <= r_fl_way + WW'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; validity alone qualifies them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_REFILL && data_ready) begin
                r_tag[r_victim][w_idx]  <= w_tag;
                r_data[r_victim][w_idx] <= data_data_rd;
            end else if (w_ready && r_req_write)
                r_data[w_hit_way][w_idx][{w_off, 5'b0} +: WORD_W] <= w_merged;
        end
    end

    assign ldst_ready   = w_ready;
    assign ldst_data_rd = w_ready ? w_hit_word : '0;
    assign flush_done   = r_flush_done;
    assign data_start   = r_data_start;
    assign data_write   = r_data_write;
    assign data_addr    = r_data_addr;
    assign data_data_wr = r_data_wdata;
    assign cnt_hit      = r_cnt_hit;
    assign cnt_miss     = r_cnt_miss;
endmodule

`default_nettype wire

// File: tb/tb_cache_l1d_assoc.sv
// ============================================================================
// Module      : tb_cache_l1d_assoc
// Description : Scoreboard bench: directed loads/stores, eviction, flush, reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cache_l1d_assoc;
    import cache_l1d_assoc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ldst_start, ldst_write, ldst_ready;
    ptr          ldst_addr;
    logic [3:0]  ldst_byte_en;
    word         ldst_data_wr, ldst_data_rd;
    logic        flush_req, flush_done;
    logic        data_start, data_write, data_ready;
    qptr         data_addr;
    qword        data_data_wr, data_data_rd;
    logic [31:0] cnt_hit, cnt_miss;

    cache_l1d_assoc #(.WAYS(2), .SETS(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .ldst_start(ldst_start), .ldst_write(ldst_write), .ldst_addr(ldst_addr),
        .ldst_byte_en(ldst_byte_en), .ldst_data_wr(ldst_data_wr),
        .ldst_ready(ldst_ready), .ldst_data_rd(ldst_data_rd),
        .flush_req(flush_req), .flush_done(flush_done),
        .data_start(data_start), .data_write(data_write), .data_addr(data_addr),
        .data_data_wr(data_data_wr), .data_data_rd(data_data_rd), .data_ready(data_ready),
        .cnt_hit(cnt_hit), .cnt_miss(cnt_miss)
    );

    always #5 clk = ~clk;

    typedef struct { logic chk; word data; } ld_exp_t;
    typedef struct { logic wr; qptr addr; qword data; } mem_exp_t;

    ld_exp_t  ld_q[$];
    mem_exp_t mem_q[$];
    qword     mem [qptr];
    int       n_checks = 0, n_errors = 0, n_flush_done = 0;

    localparam word LA = 32'h0000_AAAA, LB = 32'h0000_BBBB, LC = 32'h1122_3344, LD = 32'h0000_DDDD;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event occurred, none expected", name);
    endtask

    function automatic void exp_ld(input logic chk, input word d);
        ld_exp_t e;
        e.chk = chk; e.data = d;
        ld_q.push_back(e);
    endfunction

    function automatic void exp_mem(input logic wr, input qptr a, input qword d);
        mem_exp_t e;
        e.wr = wr; e.addr = a; e.data = d;
        mem_q.push_back(e);
    endfunction

    // Monitor: every DUT-presented event is matched against the queues.
    always @(negedge clk) begin
        ld_exp_t  le;
        mem_exp_t me;
        if (!rst && ldst_ready) begin
            if (ld_q.size() == 0) fail("ldst_ready_unexpected");
            else begin
                le = ld_q.pop_front();
                if (le.chk) check("ldst_data_rd", 128'(ldst_data_rd), 128'(le.data));
            end
        end
        if (!rst && data_start) begin
            if (mem_q.size() == 0) fail("data_start_unexpected");
            else begin
                me = mem_q.pop_front();
                check("data_write", 128'(data_write), 128'(me.wr));
                check("data_addr", 128'(data_addr), 128'(me.addr));
                if (me.wr) check("data_data_wr", data_data_wr, me.data);
            end
        end
        if (!rst && flush_done) n_flush_done++;
    end

    // Memory responder: fixed 2-cycle turnaround; keeps running through reset.
    initial begin
        qptr  a;
        logic w;
        data_ready   = 1'b0;
        data_data_rd = '0;
        @(posedge clk); #1;
        forever begin
            if (data_start && !rst) begin
                a = data_addr;
                w = data_write;
                if (w) mem[a] = data_data_wr;
                repeat (2) @(posedge clk);
                #1;
                data_data_rd = (!w && mem.exists(a)) ? mem[a] : '0;
                data_ready   = 1'b1;
                @(posedge clk); #1;
                data_ready   = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    task automatic do_req(input logic wr, input ptr addr, input logic [3:0] be, input word wd,
                          output int lat);
        ldst_write = wr; ldst_addr = addr; ldst_byte_en = be; ldst_data_wr = wd;
        ldst_start = 1'b1;
        @(posedge clk); #1;
        ldst_start = 1'b0;
        lat = 0;
        while (!ldst_ready && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ldst_ready) fail("ldst_ready_timeout");
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, cyc;
        rst = 1'b1; ldst_start = 1'b0; ldst_write = 1'b0; ldst_addr = '0;
        ldst_byte_en = '0; ldst_data_wr = '0; flush_req = 1'b0;
        mem[14'h040] = {LD, LC, LB, LA};
        mem[14'h080] = {32'h2000_0003, 32'h2000_0002, 32'h2000_0001, 32'h2000_0000};
        mem[14'h0C0] = {32'h3000_0003, 32'h3000_0002, 32'h3000_0001, 32'h3000_0000};
        mem[14'h100] = {32'h4000_0003, 32'h4000_0002, 32'h4000_0001, 32'h4000_0000};
        repeat (3) @(posedge clk);
        #1;
        check("rst_ldst_ready", 128'(ldst_ready), 0);
        check("rst_data_start", 128'(data_start), 0);
        check("rst_flush_done", 128'(flush_done), 0);
        check("rst_data_addr", 128'(data_addr), 0);
        check("rst_data_data_wr", data_data_wr, 0);
        check("rst_counters", {cnt_hit, cnt_miss}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Cold miss then refill.
        exp_mem(1'b0, 14'h040, '0); exp_ld(1'b1, LA);
        do_req(1'b0, 16'h0100, 4'h0, '0, lat);
        check("t1_cnt_miss", 128'(cnt_miss), 1);
        check("t1_cnt_hit", 128'(cnt_hit), 0);

        // Hit completes one cycle after accept.
        exp_ld(1'b1, LB);
        do_req(1'b0, 16'h0101, 4'h0, '0, lat);
        check("t2_hit_latency", 128'(lat), 0);
        check("t2_cnt_hit", 128'(cnt_hit), 1);

        // Partial store merge.
        exp_ld(1'b0, '0);
        do_req(1'b1, 16'h0102, 4'b0011, 32'hAABB_CCDD, lat);
        exp_ld(1'b1, 32'h1122_CCDD);
        do_req(1'b0, 16'h0102, 4'h0, '0, lat);
        check("t3_cnt_hit", 128'(cnt_hit), 3);

        // Fill way1 dirty, touch way0, third tag evicts way1.
        exp_mem(1'b0, 14'h080, '0); exp_ld(1'b0, '0);
        do_req(1'b1, 16'h0200, 4'hF, 32'h5555_6666, lat);
        exp_ld(1'b1, LA);
        do_req(1'b0, 16'h0100, 4'h0, '0, lat);
        exp_mem(1'b1, 14'h080, {32'h2000_0003, 32'h2000_0002, 32'h2000_0001, 32'h5555_6666});
        exp_mem(1'b0, 14'h0C0, '0); exp_ld(1'b0, '0);
        do_req(1'b1, 16'h0300, 4'hF, 32'h7777_8888, lat);
        check("t4_cnt_hit", 128'(cnt_hit), 4);
        check("t4_cnt_miss", 128'(cnt_miss), 3);

        // Flush with two dirty lines in set 0.
        exp_mem(1'b1, 14'h040, {LD, 32'h1122_CCDD, LB, LA});
        exp_mem(1'b1, 14'h0C0, {32'h3000_0003, 32'h3000_0002, 32'h3000_0001, 32'h7777_8888});
        flush_req = 1'b1;
        cyc = 0;
        while (!flush_done && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!flush_done) fail("flush_done_timeout");
        repeat (200) @(posedge clk);
        #1;
        flush_req = 1'b0;
        @(posedge clk); #1;
        check("t5_flush_done_pulses", 128'(n_flush_done), 1);
        check("t5_writebacks_pending", 128'(mem_q.size()), 0);
        check("t5_counters_frozen", {cnt_hit, cnt_miss}, {32'd4, 32'd3});
        exp_mem(1'b0, 14'h040, '0); exp_ld(1'b1, LA);
        do_req(1'b0, 16'h0100, 4'h0, '0, lat);
        exp_mem(1'b0, 14'h0C0, '0); exp_ld(1'b1, 32'h7777_8888);
        do_req(1'b0, 16'h0300, 4'h0, '0, lat);
        check("t5_cnt_miss", 128'(cnt_miss), 5);

        // Reset during refill; the late data_ready lands in IDLE.
        exp_mem(1'b0, 14'h100, '0);
        ldst_write = 1'b0; ldst_addr = 16'h0400; ldst_start = 1'b1;
        @(posedge clk); #1;
        ldst_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_data_start", 128'(data_start), 0);
        check("t6_ldst_ready", 128'(ldst_ready), 0);
        check("t6_data_addr", 128'(data_addr), 0);
        check("t6_counters", {cnt_hit, cnt_miss}, 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        exp_mem(1'b0, 14'h100, '0); exp_ld(1'b1, 32'h4000_0000);
        do_req(1'b0, 16'h0400, 4'h0, '0, lat);
        check("t6_cnt_miss", 128'(cnt_miss), 1);
        check("t6_cnt_hit", 128'(cnt_hit), 0);

        repeat (3) @(posedge clk);
        #1;
        check("end_ld_queue", 128'(ld_q.size()), 0);
        check("end_mem_queue", 128'(mem_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
